// File: rtl/result_requant_writeback_if.sv
// Row stream into the requant stage and its unified-buffer write port.
// master = upstream producer / UB side, slave = result_requant_writeback.
interface result_requant_writeback_if #(
  parameter int MATRIX_SIZE    = 64,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int DATA_BW        = 8,
  parameter int ADDRESSSIZE    = 10
);
  logic                                in_valid;
  logic                                in_ready;
  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data;
  logic                                ub_write_enable;
  logic [ADDRESSSIZE-1:0]              ub_address;
  logic [DATA_BW*MATRIX_SIZE-1:0]      ub_data_out;

  modport master (
    output in_valid, in_data,
    input  in_ready, ub_write_enable, ub_address, ub_data_out
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ub_write_enable, ub_address, ub_data_out
  );
endinterface

// File: rtl/result_requant_writeback.sv
// Requantise 24b partial-sum rows to 8b and write them back to the unified buffer.
// Optional macro REQUANT_RELU_EN clamps negative results to zero before saturation.
module requant_lane #(
  parameter int PARTIAL_SUM_BW = 24,
  parameter int DATA_BW        = 8
) (
  input  logic [4:0]                s,
  input  logic [PARTIAL_SUM_BW-1:0] x,
  output logic [DATA_BW-1:0]        y,
  output logic                      sat
);
  localparam logic signed [PARTIAL_SUM_BW:0] SMAX = (2**(DATA_BW-1)) - 1;
  localparam logic signed [PARTIAL_SUM_BW:0] SMIN = -(2**(DATA_BW-1));

  logic signed [PARTIAL_SUM_BW:0] xe, rnd, sum, sh;

  always_comb begin
    xe  = {x[PARTIAL_SUM_BW-1], x};
    rnd = '0;
    // one extra bit of headroom so the half-LSB add can never overflow
    if (s != 5'd0) rnd = {{PARTIAL_SUM_BW{1'b0}}, 1'b1} << (s - 5'd1);
    sum = xe + rnd;
    sh  = sum >>> s;
    sat = 1'b0;
    y   = sh[DATA_BW-1:0];
    if (sh > SMAX) begin
      y   = SMAX[DATA_BW-1:0];
      sat = 1'b1;
    end else if (sh < SMIN) begin
`ifdef REQUANT_RELU_EN
      y   = '0;
`else
      y   = SMIN[DATA_BW-1:0];
      sat = 1'b1;
`endif
    end
`ifdef REQUANT_RELU_EN
    else if (sh < 0) y = '0;
`endif
  end
endmodule

module result_requant_writeback #(
  parameter int MATRIX_SIZE    = 64,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int DATA_BW        = 8,
  parameter int ADDRESSSIZE    = 10,
  parameter int NUM_ROWS       = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [4:0]             shift,
  result_requant_writeback_if.slave bus,
  output logic                   busy,
  output logic                   done,
  output logic                   sat_flag
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam logic [ADDRESSSIZE-1:0] LAST_ROW  = ADDRESSSIZE'(NUM_ROWS - 1);
  localparam logic [4:0]             SHIFT_MAX = 5'(PARTIAL_SUM_BW - 1);

  state_t                               state_q, state_d;
  logic [ADDRESSSIZE-1:0]               row_cnt_q, row_cnt_d;
  logic [ADDRESSSIZE-1:0]               base_q, base_d;
  logic [4:0]                           shift_q, shift_d;
  logic                                 sat_q, sat_d;
  logic                                 wr_en_q, wr_en_d;
  logic [ADDRESSSIZE-1:0]               addr_q, addr_d;
  logic [MATRIX_SIZE-1:0][DATA_BW-1:0]  data_q, data_d;

  logic [MATRIX_SIZE-1:0][DATA_BW-1:0]  lane_y;
  logic [MATRIX_SIZE-1:0]               lane_sat;
  logic                                 hs;

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    requant_lane #(.PARTIAL_SUM_BW(PARTIAL_SUM_BW), .DATA_BW(DATA_BW)) u_lane (
      .s   (shift_q),
      .x   (bus.in_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
      .y   (lane_y[i]),
      .sat (lane_sat[i])
    );
  end

  assign hs = bus.in_valid && (state_q == RUN);

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    base_d    = base_q;
    shift_d   = shift_q;
    sat_d     = sat_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    case (state_q)
      IDLE: if (start) begin
        base_d    = base_addr;
        shift_d   = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
        row_cnt_d = '0;
        sat_d     = 1'b0;
        state_d   = RUN;
      end
      RUN: if (hs) begin
        wr_en_d   = 1'b1;
        addr_d    = base_q + row_cnt_q;
        data_d    = lane_y;
        sat_d     = sat_q | (|lane_sat);
        row_cnt_d = row_cnt_q + ADDRESSSIZE'(1);
        if (row_cnt_q == LAST_ROW) state_d = FLUSH;
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      base_q    <= '0;
      shift_q   <= '0;
      sat_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      base_q    <= base_d;
      shift_q   <= shift_d;
      sat_q     <= sat_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign bus.in_ready        = (state_q == RUN);
  assign bus.ub_write_enable = wr_en_q;
  assign bus.ub_address      = addr_q;
  assign bus.ub_data_out     = data_q;
  assign busy                = (state_q == RUN) || (state_q == FLUSH);
  assign done                = (state_q == DONE);
  assign sat_flag            = sat_q;
endmodule

// File: tb/tb_result_requant_writeback.sv
// Directed bench for result_requant_writeback: scoreboarded UB writes plus
// FSM/status checks around reset, rounding, saturation, wrap and abort.
module tb_result_requant_writeback;
  localparam int MS = 64, PSB = 24, DBW = 8, AW = 10, NR = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW-1:0] base_addr;
  logic [4:0]    shift;
  logic          busy, done, sat_flag;

  result_requant_writeback_if #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSB),
    .DATA_BW(DBW), .ADDRESSSIZE(AW)) bus ();

  result_requant_writeback #(.MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSB), .DATA_BW(DBW),
    .ADDRESSSIZE(AW), .NUM_ROWS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .shift(shift),
    .bus(bus.slave), .busy(busy), .done(done), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [MS*DBW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0, errors = 0;
  int            lanes[MS];
  int            cur_shift;
  logic [AW-1:0] exp_addr;
  logic          sat_exp;

  task automatic chk(input string tag, input logic [MS*DBW-1:0] obs, input logic [MS*DBW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int rq_raw(int x, int s);
    int y;
    y = (s > 0) ? ((x + (1 << (s - 1))) >>> s) : x;
`ifdef REQUANT_RELU_EN
    if (y < 0) y = 0;
`endif
    return y;
  endfunction

  function automatic logic [DBW-1:0] rq(int x, int s);
    int y;
    y = rq_raw(x, s);
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return y[DBW-1:0];
  endfunction

  task automatic set_pattern(input int a, input int b, input int c, input int d, input int e, input int n);
    int p[5];
    p = '{a, b, c, d, e};
    for (int i = 0; i < MS; i++) lanes[i] = p[i % n];
  endtask

  // write monitor: every strobe must match the oldest expected row
  always @(negedge clk) begin
    exp_t e;
    if (bus.ub_write_enable === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", bus.ub_address, e.addr);
        chk("wr_data", bus.ub_data_out, e.data);
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [4:0] s);
    @(negedge clk);
    start = 1'b1; base_addr = b; shift = s;
    @(posedge clk); #1;
    start = 1'b0;
    cur_shift = (s > 23) ? 23 : int'(s);
    exp_addr  = b;
    sat_exp   = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_sat_clr", sat_flag, 0);
  endtask

  task automatic send_row();
    logic [MS*PSB-1:0] d;
    exp_t e;
    int   n, y;
    for (int i = 0; i < MS; i++) begin
      d[i*PSB +: PSB]   = lanes[i][PSB-1:0];
      e.data[i*DBW +: DBW] = rq(lanes[i], cur_shift);
      y = rq_raw(lanes[i], cur_shift);
      if (y > 127 || y < -128) sat_exp = 1'b1;
    end
    e.addr = exp_addr;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n == 20) chk("ready_timeout", 0, 1);
    sb.push_back(e);
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_burst(input string tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_flush_busy"}, busy, 1);
    chk({tag, "_flush_done"}, done, 0);
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_sat"}, sat_flag, sat_exp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_ready"}, bus.in_ready, 0);
    chk({tag, "_sat_held"}, sat_flag, sat_exp);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; shift = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", bus.ub_write_enable, 0);
    chk("rst_addr", bus.ub_address, 0);
    chk("rst_data", bus.ub_data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ready", bus.in_ready, 0);

    // basic burst, lanes = row index
    do_start(10'h010, 5'd0);
    for (int k = 0; k < NR; k++) begin
      set_pattern(k, k, k, k, k, 1);
      send_row();
    end
    finish_burst("basic");

    // round half up at shift 4
    do_start(10'h040, 5'd4);
    set_pattern(8, 7, -8, -9, 24, 5);
    repeat (NR) send_row();
    finish_burst("round");

    // saturation, sticky through done
    do_start(10'h080, 5'd0);
    set_pattern(200, -200, 127, -128, 0, 4);
    repeat (NR) send_row();
    finish_burst("sat");

    // shift clamp: 31 behaves as 23
    do_start(10'h0C0, 5'd31);
    set_pattern(8388607, -8388608, 4194303, 4194304, -4194305, 5);
    repeat (NR) send_row();
    finish_burst("clamp");

    // gaps, wrap and an ignored mid-burst start
    do_start(10'h3FE, 5'd1);
    for (int k = 0; k < NR; k++) begin
      set_pattern(k * 5 - 7, -k, k * 100, 3, -3, 5);
      send_row();
      if (k < NR - 1) gap();
      if (k == 1) begin
        @(negedge clk);
        bus.in_valid = 1'b0; start = 1'b1; base_addr = 10'h100; shift = 5'd0;
        @(posedge clk); #1 start = 1'b0;
      end
    end
    finish_burst("wrap");

    // reset after two of four rows
    do_start(10'h020, 5'd0);
    set_pattern(1, 2, 3, 4, 5, 5);
    send_row();
    send_row();
    @(negedge clk);
    bus.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_wr_en", bus.ub_write_enable, 0);
    chk("abort_addr", bus.ub_address, 0);
    chk("abort_data", bus.ub_data_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", bus.in_ready, 0);
    chk("abort_sb_empty", sb.size(), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    do_start(10'h030, 5'd2);
    set_pattern(-6, 6, 1000, -1000, 2, 5);
    repeat (NR) send_row();
    finish_burst("refresh");

`ifdef REQUANT_RELU_EN
    do_start(10'h050, 5'd0);
    set_pattern(-50, 50, 300, 0, 0, 3);
    repeat (NR) send_row();
    finish_burst("relu_sat");
    do_start(10'h060, 5'd0);
    set_pattern(-50, 50, -300, -1, 0, 4);
    repeat (NR) send_row();
    finish_burst("relu_neg");
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/result_requant_writeback.md
Name: result_requant_writeback

Overview:
- Downstream stage of the 1x64 vector multiplier. Consumes 64-lane rows of signed partial sums (24 b/lane) from the results path.
- Each lane is rounded, arithmetically right-shifted and saturated to 8 b. The packed 512-bit row is written back into the unified buffer, so the next layer can use it as activations.
- Runs one burst of NUM_ROWS rows per start, at a controller-supplied base address. Reports busy, done and saturation status.

Parameters:
- MATRIX_SIZE, 64, lanes per row
- PARTIAL_SUM_BW, 24, input lane width (signed)
- DATA_BW, 8, output lane width (signed)
- ADDRESSSIZE, 10, unified-buffer address width
- NUM_ROWS, 64, rows per burst (1..2^ADDRESSSIZE)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  burst start pulse; sampled in IDLE only
- base_addr  in  ADDRESSSIZE  first UB write address; latched on start
- shift  in  5  right-shift amount; latched on start; values >PARTIAL_SUM_BW-1 clamp to PARTIAL_SUM_BW-1
- in_valid  in  1  input row valid
- in_ready  out  1  block accepts a row this cycle
- in_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  lane i at [i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]
- ub_write_enable  out  1  UB write strobe
- ub_address  out  ADDRESSSIZE  UB write address
- ub_data_out  out  DATA_BW*MATRIX_SIZE  lane i at [i*DATA_BW +: DATA_BW]
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle pulse at burst completion
- sat_flag  out  1  sticky: any lane saturated during the current/last burst

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, state=IDLE, counters 0. Reset mid-burst aborts the burst immediately. No pending write is issued after reset.
- State machine states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - in_ready=0.
  - On start: latch base_addr and clamped shift; row_cnt=0; clear sat_flag; go to RUN.
- RUN:
  - in_ready=1.
  - Handshake: in_valid & in_ready. On handshake, row_cnt increments.
  - When the handshake accepts row NUM_ROWS-1, go to FLUSH.
  - start is ignored.
- FLUSH: in_ready=0. Lasts exactly one cycle, for the final write. Then go to DONE.
- DONE: done=1 for one cycle, busy=0. Go to IDLE. A start in the DONE cycle is ignored.
- Latency: a row accepted at edge t appears at edge t+1:
  - ub_write_enable=1;
  - ub_address = base + k (mod 2^ADDRESSSIZE), where k is the row index;
  - ub_data_out = the requantised row.
- ub_write_enable is 0 on every cycle without a preceding handshake. Gaps (in_valid=0) are allowed.
- Address wraps modulo 2^ADDRESSSIZE. No error on wrap.
- Per-lane arithmetic, with x signed PARTIAL_SUM_BW and s = latched shift:
  - if s>0: y = (x + 2^(s-1)) >>> s, computed in PARTIAL_SUM_BW+1 bits so no overflow (round half up);
  - if s=0: y = x.
  - Saturate y to [-128,127]. Saturation sets sat_flag (sticky until the next start).
- busy = (state==RUN) | (state==FLUSH).

Optional Feature:
- Macro REQUANT_RELU_EN.
- Defined: after rounding/shift and before saturation, negative y is forced to 0. Outputs then lie in [0,127]. A negative input never sets sat_flag.
- Undefined: signed path exactly as in Behaviour.

Test Plan:
- Basic burst: rst, start with base=0x010, shift=0, NUM_ROWS=4. Rows with all lanes = k (k=0..3), in_valid continuous.
  -> writes at 0x010..0x013 one cycle after each accept, every lane = k; done pulses 1 cycle after FLUSH; sat_flag=0.
- Rounding: shift=4. Lanes 8, 7, -8, -9, 24.
  -> outputs 1, 0, 0, -1, 2.
- Saturation: shift=0. Lanes 200, -200, 127, -128.
  -> 127, -128, 127, -128; sat_flag=1, held through done; cleared on the next start.
- Gaps and wrap: base=0x3FE, NUM_ROWS=4, in_valid toggled 1,0,1,0,...
  -> addresses 0x3FE, 0x3FF, 0x000, 0x001; ub_write_enable low during gaps; start pulsed mid-burst is ignored.
- Reset mid-burst: rst after 2 of 4 rows.
  -> next cycle all outputs 0, state IDLE, no further writes, no done; a fresh start runs a full 4-row burst.
- REQUANT_RELU_EN defined: lanes -50, 50, 300.
  -> 0, 50, 127; sat_flag=1 from the 300 only.
